ex_div_seq: RTL and testbench
=============================

EX_DIV_SEQ -- requirements
Module: ex_div_seq

Interface
REQ-001 Parameter: DATA_W, default 32, operand width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 start_i  in  1  divide request from EX; held high until ready_o is seen.
REQ-005 annul_i  in  1  abort, e.g. on a pipeline flush.
REQ-006 signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-007 opdata1_i  in  32  dividend.
REQ-008 opdata2_i  in  32  divisor.
REQ-009 result_o  out  64  {remainder[63:32], quotient[31:0]}.
REQ-010 ready_o  out  1  result_o valid.
REQ-011 stallreq_o  out  1  EX stall request to the pipeline control.

Function
REQ-012 The block SHALL implement a four-state FSM: FREE, BYZERO, ON and END.
REQ-013 In FREE, when start_i=1 and annul_i=0, the block SHALL capture signed_div_i, opdata1_i and opdata2_i, and SHALL go to BYZERO if opdata2_i==0, else to ON with iteration counter cnt=0.
REQ-014 In FREE with no accepted request, the block SHALL hold result_o=0 and ready_o=0.
REQ-015 When signed, operands SHALL be converted to magnitude (two's-complement negate if bit 31 is set) at capture; the original signs SHALL be kept.
REQ-016 In ON, each rising edge SHALL perform one restoring-division step (shift, trial subtract, quotient bit = no-borrow) and increment cnt.
REQ-017 In ON, the step completing the 32nd iteration (cnt 31) SHALL transition to END and register the corrected result.
REQ-018 Sign correction (signed only): quotient SHALL be negated if the dividend and divisor signs differ, and remainder SHALL be negated if the dividend is negative.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (two's-complement wrap, no trap).
REQ-020 BYZERO SHALL go to END on the next edge with result=0.
REQ-021 In END, ready_o=1 and result_o=registered result for as long as start_i=1.
REQ-022 When start_i=0 in END, the next edge SHALL go to FREE, clearing ready_o and result_o.
REQ-023 annul_i=1 in ON or BYZERO SHALL force FREE on the next edge, with no result and ready_o never asserted.
REQ-024 annul_i=1 in FREE SHALL block acceptance.
REQ-025 Deassertion of start_i while in ON or BYZERO SHALL be ignored; only annul_i aborts.
REQ-026 Operand changes after capture SHALL NOT affect the result.
REQ-027 stallreq_o SHALL be 1 when:
- in FREE with start_i=1 and annul_i=0; or
- in ON or BYZERO with annul_i=0.
REQ-028 stallreq_o SHALL be 0 in END and otherwise.
REQ-029 Latency (accepting edge = edge 1):
- nonzero divisor: ready_o=1 after edge 33;
- zero divisor: ready_o=1 after edge 2.
REQ-030 ready_o and result_o SHALL be registered outputs; stallreq_o may be combinational from state and inputs.
REQ-031 If start_i stays high after result consumption, a new request SHALL be accepted only after returning to FREE; there is no back-to-back acceptance from END.

Reset
REQ-032 rst=0 SHALL immediately, without waiting for a clock edge, force:
- state=FREE and cnt=0;
- result_o=0 and ready_o=0;
- all captured operand and sign registers = 0.
REQ-033 Reset asserted mid-operation SHALL discard the division; after release the block SHALL be idle in FREE.

Verification
REQ-034 Unsigned 100/7, start held -> stallreq_o=1 for 33 cycles; then ready_o=1 and result_o=0x00000002_0000000E.
REQ-035 Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD; signed 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000.
REQ-036 Unsigned 0xFFFFFFFF/0 -> ready_o=1 after edge 2 with result_o=0; dropping start_i -> FREE, ready_o=0.
REQ-037 Start 1000/3, pulse annul_i at iteration 10 -> FREE next edge, stallreq_o=0, ready_o stays 0; a following 9/3 request -> result_o=0x00000000_00000003.
REQ-038 Assert rst=0 at iteration 20 -> outputs 0 immediately without a clock edge; operands changed during ON do not alter the result of an unannulled 100/7.

Source files
------------

// File: rtl/ex_div_seq.sv
// Sequential 32-cycle restoring divider for the EX stage.
// Handles DIV/DIVU, divide-by-zero, annul and pipeline stall.
module ex_div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] ONE_W =
    {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_FREE,
    ST_BYZERO,
    ST_ON,
    ST_END
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                sgn_q, sgn_d;
  logic                neg1_q, neg1_d;
  logic                neg2_q, neg2_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic                rdy_q, rdy_d;
  logic                stall;

  logic [DATA_W:0]     part;
  logic [DATA_W+1:0]   diff;
  logic                borrow;
  logic [DATA_W-1:0]   rem_nxt;
  logic [DATA_W-1:0]   quo_nxt;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic                cap_neg1;
  logic                cap_neg2;
  logic [DATA_W-1:0]   cap_mag1;
  logic [DATA_W-1:0]   cap_mag2;
  logic                unused_diff;

  function automatic logic [DATA_W-1:0] negate(
    input logic [DATA_W-1:0] v
  );
    return ~v + ONE_W;
  endfunction

  // Operand capture: signs kept, magnitudes fed to the array.
  always_comb begin
    cap_neg1 = signed_div_i & opdata1_i[DATA_W-1];
    cap_neg2 = signed_div_i & opdata2_i[DATA_W-1];
    cap_mag1 = cap_neg1 ? negate(opdata1_i) : opdata1_i;
    cap_mag2 = cap_neg2 ? negate(opdata2_i) : opdata2_i;
  end

  // One restoring step: shift in next dividend bit, trial subtract.
  always_comb begin
    part     = {rem_q, quo_q[DATA_W-1]};
    diff     = {1'b0, part} - {2'b00, dvs_q};
    borrow   = diff[DATA_W+1];
    rem_nxt  = borrow ? part[DATA_W-1:0] : diff[DATA_W-1:0];
    quo_nxt  = {quo_q[DATA_W-2:0], ~borrow};
    unused_diff = diff[DATA_W];
  end

  // Sign fix-up applied to the final step's outputs.
  always_comb begin
    quo_fix = quo_nxt;
    rem_fix = rem_nxt;
    if (sgn_q && (neg1_q ^ neg2_q)) begin
      quo_fix = negate(quo_nxt);
    end
    if (sgn_q && neg1_q) begin
      rem_fix = negate(rem_nxt);
    end
  end

  // Next-state, datapath updates and stall request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    sgn_d   = sgn_q;
    neg1_d  = neg1_q;
    neg2_d  = neg2_q;
    res_d   = res_q;
    rdy_d   = rdy_q;
    stall   = 1'b0;
    unique case (state_q)
      ST_FREE: begin
        res_d = '0;
        rdy_d = 1'b0;
        if (start_i && !annul_i) begin
          stall  = 1'b1;
          sgn_d  = signed_div_i;
          neg1_d = cap_neg1;
          neg2_d = cap_neg2;
          quo_d  = cap_mag1;
          dvs_d  = cap_mag2;
          rem_d  = '0;
          cnt_d  = '0;
          if (opdata2_i == '0) begin
            state_d = ST_BYZERO;
          end else begin
            state_d = ST_ON;
          end
        end
      end
      ST_BYZERO: begin
        if (annul_i) begin
          state_d = ST_FREE;
        end else begin
          stall   = 1'b1;
          state_d = ST_END;
          res_d   = '0;
          rdy_d   = 1'b1;
        end
      end
      ST_ON: begin
        if (annul_i) begin
          state_d = ST_FREE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_END;
            cnt_d   = '0;
            res_d   = {rem_fix, quo_fix};
            rdy_d   = 1'b1;
          end
        end
      end
      ST_END: begin
        if (!start_i) begin
          state_d = ST_FREE;
          res_d   = '0;
          rdy_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_FREE;
        res_d   = '0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FREE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      sgn_q   <= 1'b0;
      neg1_q  <= 1'b0;
      neg2_q  <= 1'b0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      neg1_q  <= neg1_d;
      neg2_q  <= neg2_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
    end
  end

  assign result_o   = res_q;
  assign ready_o    = rdy_q;
  assign stallreq_o = stall;

endmodule

// File: tb/tb_ex_div_seq.sv
// Directed bench for ex_div_seq: vector table plus
// annul, reset and operand-change sequences.
module tb_ex_div_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_vec = 0;
  int n_bad = 0;

  ex_div_seq #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns at the same phase.
  task automatic run_div(input logic sgn,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input bit scr,
                         output logic [63:0] res,
                         output int lat,
                         output int stl);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat = 99;
    stl = 0;
    res = '0;
    for (int e = 1; e <= 40; e++) begin
      #1;
      if (stallreq_o) stl++;
      @(posedge clk);
      #1;
      if (scr && e == 1) begin
        opdata1_i    = 32'h0000_0005;
        opdata2_i    = 32'h0;
        signed_div_i = ~sgn;
      end
      if (ready_o) begin
        lat = e;
        res = result_o;
        break;
      end
    end
  endtask

  logic [63:0] res;
  int          lat;
  int          stl;
  bit          rdy_seen;

  initial begin
    vt[0]  = '{1'b0, 32'd100,        32'd7,
               64'h00000002_0000000E, 33};
    vt[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002,
               64'hFFFFFFFF_FFFFFFFD, 33};
    vt[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,
               64'h00000000_80000000, 33};
    vt[3]  = '{1'b0, 32'hFFFFFFFF,   32'h00000000,
               64'h00000000_00000000, 2};
    vt[4]  = '{1'b0, 32'd9,          32'd3,
               64'h00000000_00000003, 33};
    vt[5]  = '{1'b0, 32'hFFFFFFFF,   32'h00000001,
               64'h00000000_FFFFFFFF, 33};
    vt[6]  = '{1'b1, 32'h00000007,   32'hFFFFFFFE,
               64'h00000001_FFFFFFFD, 33};
    vt[7]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,
               64'hFFFFFFFF_00000003, 33};
    vt[8]  = '{1'b0, 32'd5,          32'd10,
               64'h00000005_00000000, 33};
    vt[9]  = '{1'b0, 32'hFFFFFFFF,   32'h00000010,
               64'h0000000F_0FFFFFFF, 33};
    vt[10] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,
               64'h80000000_00000000, 33};
    vt[11] = '{1'b1, 32'h00000000,   32'h00000000,
               64'h00000000_00000000, 2};

    rst          = 1'b0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    #12;
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      run_div(vt[i].sgn, vt[i].a, vt[i].b, 1'b0,
              res, lat, stl);
      chk($sformatf("v%0d_result", i), res, vt[i].exp);
      chk($sformatf("v%0d_latency", i),
          64'(lat), 64'(vt[i].lat));
      chk($sformatf("v%0d_stall_cycles", i),
          64'(stl), 64'(vt[i].lat));
      #1;
      chk($sformatf("v%0d_end_stall", i),
          64'(stallreq_o), 64'd0);
      repeat (2) begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("v%0d_hold_ready", i),
          64'(ready_o), 64'd1);
      chk($sformatf("v%0d_hold_result", i),
          result_o, vt[i].exp);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_drop_ready", i),
          64'(ready_o), 64'd0);
      chk($sformatf("v%0d_drop_result", i),
          result_o, 64'd0);
    end

    // Annul at iteration 10 of 1000/3
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    rdy_seen     = 1'b0;
    repeat (11) begin
      @(posedge clk);
      #1;
      if (ready_o) rdy_seen = 1'b1;
    end
    annul_i = 1'b1;
    #1;
    chk("annul_on_stall", 64'(stallreq_o), 64'd0);
    @(posedge clk);
    #1;
    chk("annul_ready", 64'(ready_o), 64'd0);
    chk("annul_result", result_o, 64'd0);
    chk("annul_free_stall", 64'(stallreq_o), 64'd0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    #1;
    chk("annul_blocks_accept", 64'(stallreq_o), 64'd0);
    chk("annul_no_ready", 64'(rdy_seen), 64'd0);
    @(posedge clk);
    #1;
    run_div(1'b0, 32'd9, 32'd3, 1'b0, res, lat, stl);
    chk("after_annul_result", res, 64'h00000000_00000003);
    chk("after_annul_latency", 64'(lat), 64'd33);

    // Operand changes after capture, then reset while in END
    start_i = 1'b0;
    @(posedge clk);
    #1;
    run_div(1'b0, 32'd100, 32'd7, 1'b1, res, lat, stl);
    chk("scramble_result", res, 64'h00000002_0000000E);
    chk("scramble_latency", 64'(lat), 64'd33);
    rst = 1'b0;
    #1;
    chk("rst_end_ready", 64'(ready_o), 64'd0);
    chk("rst_end_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset at iteration 20 of 100/7
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (21) begin
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    rst     = 1'b0;
    #1;
    chk("rst_mid_stall", 64'(stallreq_o), 64'd0);
    chk("rst_mid_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    rdy_seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) rdy_seen = 1'b1;
    end
    chk("rst_mid_no_ready", 64'(rdy_seen), 64'd0);
    chk("rst_mid_idle_stall", 64'(stallreq_o), 64'd0);
    chk("rst_mid_idle_result", result_o, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
